decode_stage_hz: RTL

Parametrised successor of the MIPS decode stage. Contains:
- the IF/ID pipeline register, with stall and flush,
- a register file of configurable width and depth, with asynchronous reset and optional write-to-read bypass,
- the instruction field parser and immediate extender,
- the control unit, with valid gating and an illegal-instruction flag,
- load-use hazard detection, which stalls IF and injects a bubble into EX.

It sits between the IF stage and the ID/EX register.

---
 rtl/decode_stage_hz.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage_hz.sv
// Decode stage: IF/ID register, register file, field parser, control decode
// and load-use hazard detection sitting between IF and the ID/EX register.
module decode_stage_hz #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int BYPASS   = 1,
  parameter int ILLCNT_W = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [31:0]         instr_in,
  input  logic [31:0]         pc_plus4_in,
  input  logic                valid_in,
  input  logic                stall_in,
  input  logic                flush_in,
  input  logic                wb_we,
  input  logic [4:0]          wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                ex_valid,
  input  logic                ex_memtoreg,
  input  logic [4:0]          ex_rt_addr,
  output logic [31:0]         pc_plus4_out,
  output logic                valid_out,
  output logic [4:0]          rs_addr,
  output logic [4:0]          rt_addr,
  output logic [4:0]          rd_addr,
  output logic [4:0]          shamt,
  output logic [25:0]         j_addr,
  output logic [XLEN-1:0]     imm_sext,
  output logic [XLEN-1:0]     imm_zext,
  output logic [XLEN-1:0]     rs_data,
  output logic [XLEN-1:0]     rt_data,
  output logic                RegWriteD,
  output logic                MemtoRegD,
  output logic                MemWriteD,
  output logic                BranchD,
  output logic                JumpD,
  output logic                RegDstD,
  output logic                LinkD,
  output logic [5:0]          ALUopD,
  output logic [5:0]          ALUfunctD,
  output logic                illegal,
  output logic                stall_out,
  output logic [ILLCNT_W-1:0] ill_cnt
);

  localparam int AW = $clog2(NREG);
  localparam logic [5:0] NREG_L = 6'(NREG);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;

  logic [31:0]         instr_r;
  logic [31:0]         pc_r;
  logic                valid_r;
  logic [XLEN-1:0]     regs_r [NREG];
  logic [ILLCNT_W-1:0] cnt_r;
  logic                hazard_s;
  logic                legal_s, rw_s, m2r_s, mw_s, br_s, jmp_s, rdst_s, lnk_s;

  // Register 0 and addresses beyond the implemented file are hard-wired to zero.
  function automatic logic addr_ok(input logic [4:0] a);
    return (a != 5'd0) && ({1'b0, a} < NREG_L);
  endfunction

  assign rs_addr      = instr_r[25:21];
  assign rt_addr      = instr_r[20:16];
  assign rd_addr      = instr_r[15:11];
  assign shamt        = instr_r[10:6];
  assign j_addr       = instr_r[25:0];
  assign ALUopD       = instr_r[31:26];
  assign ALUfunctD    = instr_r[5:0];
  assign imm_sext     = {{(XLEN-16){instr_r[15]}}, instr_r[15:0]};
  assign imm_zext     = {{(XLEN-16){1'b0}}, instr_r[15:0]};
  assign pc_plus4_out = pc_r;
  assign ill_cnt      = cnt_r;

  assign hazard_s  = valid_r && ex_valid && ex_memtoreg && (ex_rt_addr != 5'd0) &&
                     ((ex_rt_addr == rs_addr) || (ex_rt_addr == rt_addr));
  assign stall_out = hazard_s | stall_in;
  assign valid_out = valid_r & ~hazard_s;

  // IF/ID pipeline register: flush beats stall/hazard hold, which beats load.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      instr_r <= 32'd0;
      valid_r <= 1'b0;
      pc_r    <= 32'd0;
    end else if (flush_in) begin
      instr_r <= 32'd0;
      valid_r <= 1'b0;
      pc_r    <= pc_plus4_in;
    end else if (stall_in || hazard_s) begin
      instr_r <= instr_r;
      valid_r <= valid_r;
      pc_r    <= pc_r;
    end else begin
      instr_r <= instr_in;
      valid_r <= valid_in;
      pc_r    <= pc_plus4_in;
    end
  end

  // Register file write port.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wb_we && addr_ok(wb_addr)) begin
      regs_r[wb_addr[AW-1:0]] <= wb_data;
    end
  end

  // Combinational read ports with optional same-cycle forwarding from WB.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (!addr_ok(rs_addr)) begin
      rs_data = '0;
    end else if ((BYPASS != 0) && wb_we && (wb_addr == rs_addr)) begin
      rs_data = wb_data;
    end else begin
      rs_data = regs_r[rs_addr[AW-1:0]];
    end
    if (!addr_ok(rt_addr)) begin
      rt_data = '0;
    end else if ((BYPASS != 0) && wb_we && (wb_addr == rt_addr)) begin
      rt_data = wb_data;
    end else begin
      rt_data = regs_r[rt_addr[AW-1:0]];
    end
  end

  // Main control decode; unrecognised encodings leave every control bit low.
  always_comb begin
    legal_s = 1'b0;
    rw_s    = 1'b0;
    m2r_s   = 1'b0;
    mw_s    = 1'b0;
    br_s    = 1'b0;
    jmp_s   = 1'b0;
    rdst_s  = 1'b0;
    lnk_s   = 1'b0;
    case (instr_r[31:26])
      OP_RTYPE: begin
        case (instr_r[5:0])
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT,
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV: begin
            legal_s = 1'b1;
            rw_s    = 1'b1;
            rdst_s  = 1'b1;
          end
          F_JR: begin
            legal_s = 1'b1;
            jmp_s   = 1'b1;
            rdst_s  = 1'b1;
          end
          default: legal_s = 1'b0;
        endcase
      end
      OP_LW: begin
        legal_s = 1'b1;
        rw_s    = 1'b1;
        m2r_s   = 1'b1;
      end
      OP_SW: begin
        legal_s = 1'b1;
        mw_s    = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        legal_s = 1'b1;
        br_s    = 1'b1;
      end
      OP_J: begin
        legal_s = 1'b1;
        jmp_s   = 1'b1;
      end
      OP_JAL: begin
        legal_s = 1'b1;
        rw_s    = 1'b1;
        jmp_s   = 1'b1;
        lnk_s   = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: begin
        legal_s = 1'b1;
        rw_s    = 1'b1;
      end
      default: legal_s = 1'b0;
    endcase
  end

  assign RegWriteD = valid_out & rw_s;
  assign MemtoRegD = valid_out & m2r_s;
  assign MemWriteD = valid_out & mw_s;
  assign BranchD   = valid_out & br_s;
  assign JumpD     = valid_out & jmp_s;
  assign RegDstD   = valid_out & rdst_s;
  assign LinkD     = valid_out & lnk_s;
  assign illegal   = valid_out & ~legal_s;

  // Saturating illegal-instruction counter; stalled or flushed slots do not count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_r <= '0;
    end else if (illegal && !stall_in && !flush_in && (cnt_r != {ILLCNT_W{1'b1}})) begin
      cnt_r <= cnt_r + ILLCNT_W'(1'b1);
    end
  end

endmodule
